result_serializer: RTL and testbench

Parallel-to-serial unloader for the cascade multiplier datapath. It captures the WIDTH one-bit column outputs of the compressor (dst0..dst{WIDTH-1}) as one word and streams them out LSB-first on a single-bit valid/ready channel. An optional even-parity bit can be appended to each frame. It is the output-side counterpart of the input shift register that serially loads the compressor's column registers, so the whole multiplier can be driven and checked through a few pins.

---
 rtl/cascade_pkg.sv | 16 +
 rtl/result_serializer_if.sv | 42 ++++
 rtl/result_serializer.sv | 121 ++++++++++++
 tb/tb_result_serializer.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cascade_pkg.sv
// Shared definitions for the cascade multiplier datapath: serializer FSM
// states and the default frame geometry.
package cascade_pkg;

  // Serializer FSM states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    PAR  = 2'd2
  } state_t;

  // Default frame geometry: one bit per compressor column, even parity on
  localparam int unsigned WIDTH  = 52;
  localparam int unsigned PARITY = 1;

endpackage

// File: rtl/result_serializer_if.sv
// Load and serial channels of the result serializer.
//   load_valid/load_ready/din      : parallel word handshake (upstream -> serializer)
//   ser_out/ser_valid/ser_last     : serial bit stream (serializer -> downstream)
//   ser_ready                      : downstream accepts the current bit
//   busy                           : a frame is in progress
// The slave modport is the serializer's view; master is the driver's view.
interface result_serializer_if #(
  parameter int unsigned WIDTH = cascade_pkg::WIDTH
);

  logic             load_valid;
  logic             load_ready;
  logic [WIDTH-1:0] din;
  logic             ser_out;
  logic             ser_valid;
  logic             ser_last;
  logic             ser_ready;
  logic             busy;

  modport slave (
    input  load_valid,
    input  din,
    input  ser_ready,
    output load_ready,
    output ser_out,
    output ser_valid,
    output ser_last,
    output busy
  );

  modport master (
    output load_valid,
    output din,
    output ser_ready,
    input  load_ready,
    input  ser_out,
    input  ser_valid,
    input  ser_last,
    input  busy
  );

endinterface

// File: rtl/result_serializer.sv
// Parallel-to-serial unloader for the compressor column outputs.
// Captures a WIDTH-bit word and streams it LSB-first on a single-bit
// valid/ready channel, optionally followed by an even-parity bit.
// Ports:
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : result_serializer_if.slave (load handshake, serial stream, busy)
// All outputs are registered.
module result_serializer #(
  parameter int unsigned WIDTH  = cascade_pkg::WIDTH,
  parameter int unsigned PARITY = cascade_pkg::PARITY
) (
  input  logic           clk,
  input  logic           rst_n,
  result_serializer_if.slave bus
);

  import cascade_pkg::*;

  localparam int unsigned   CW       = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 1);
  localparam logic [CW-1:0] PEN_IDX  = CW'(WIDTH - 2);
  localparam bit            HAS_PAR  = (PARITY != 0);

  state_t           state;
  logic [WIDTH-1:0] shreg;
  logic [CW-1:0]    cnt;
  logic             par;

  logic load_ready_q;
  logic ser_out_q;
  logic ser_valid_q;
  logic ser_last_q;
  logic busy_q;

  logic bit_taken;

  // Current serial bit consumed by downstream this cycle
  assign bit_taken = ser_valid_q & bus.ser_ready;

  assign bus.load_ready = load_ready_q;
  assign bus.ser_out    = ser_out_q;
  assign bus.ser_valid  = ser_valid_q;
  assign bus.ser_last   = ser_last_q;
  assign bus.busy       = busy_q;

  // FSM, shift/count datapath and registered outputs.
  // ser_out is loaded with the bit that will sit in shreg[0] after the
  // same edge, so ser_out always mirrors shreg[0] while in DATA.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      shreg        <= '0;
      cnt          <= '0;
      par          <= 1'b0;
      load_ready_q <= 1'b0;
      ser_out_q    <= 1'b0;
      ser_valid_q  <= 1'b0;
      ser_last_q   <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          load_ready_q <= 1'b1;
          if (bus.load_valid && load_ready_q) begin
            shreg        <= bus.din;
            cnt          <= '0;
            par          <= ^bus.din;
            state        <= DATA;
            load_ready_q <= 1'b0;
            ser_valid_q  <= 1'b1;
            ser_out_q    <= bus.din[0];
            ser_last_q   <= 1'b0;
            busy_q       <= 1'b1;
          end
        end

        DATA: begin
          if (bit_taken) begin
            shreg <= shreg >> 1;
            if (cnt == LAST_IDX) begin
              if (HAS_PAR) begin
                state      <= PAR;
                ser_out_q  <= par;
                ser_last_q <= 1'b1;
              end else begin
                state        <= IDLE;
                ser_valid_q  <= 1'b0;
                ser_out_q    <= 1'b0;
                ser_last_q   <= 1'b0;
                busy_q       <= 1'b0;
                load_ready_q <= 1'b1;
              end
            end else begin
              cnt        <= cnt + 1'b1;
              ser_out_q  <= shreg[1];
              // Without parity the final data bit carries ser_last
              ser_last_q <= !HAS_PAR && (cnt == PEN_IDX);
            end
          end
        end

        PAR: begin
          if (bit_taken) begin
            state        <= IDLE;
            ser_valid_q  <= 1'b0;
            ser_out_q    <= 1'b0;
            ser_last_q   <= 1'b0;
            busy_q       <= 1'b0;
            load_ready_q <= 1'b1;
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_result_serializer.sv
// Self-checking bench for result_serializer: one instance with parity,
// one without, directed plus randomized frames against a frame model.
module tb_result_serializer;

  localparam int unsigned W = 52;

  logic clk;
  logic rst_n;
  logic sel;          // 1: parity instance, 0: no-parity instance
  logic lv;
  logic rdy;
  logic [W-1:0] din_r;

  int n_cmp;
  int n_err;

  logic [63:0] got_bits;
  logic [63:0] got_last;
  int          busy_cnt;
  int          n_unstable;
  int          ngot;
  int          load_wait;

  result_serializer_if #(.WIDTH(W)) bus1 ();
  result_serializer_if #(.WIDTH(W)) bus0 ();

  result_serializer #(.WIDTH(W), .PARITY(1)) u_dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus1)
  );

  result_serializer #(.WIDTH(W), .PARITY(0)) u_dut0 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus0)
  );

  assign bus1.load_valid = lv & sel;
  assign bus0.load_valid = lv & ~sel;
  assign bus1.ser_ready  = rdy & sel;
  assign bus0.ser_ready  = rdy & ~sel;
  assign bus1.din        = din_r;
  assign bus0.din        = din_r;

  logic o_lready, o_valid, o_out, o_last, o_busy;
  assign o_lready = sel ? bus1.load_ready : bus0.load_ready;
  assign o_valid  = sel ? bus1.ser_valid  : bus0.ser_valid;
  assign o_out    = sel ? bus1.ser_out    : bus0.ser_out;
  assign o_last   = sel ? bus1.ser_last   : bus0.ser_last;
  assign o_busy   = sel ? bus1.busy       : bus0.busy;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // Reference frame: data bits LSB-first, then even parity of the word
  function automatic logic [63:0] model_frame(input logic [W-1:0] w, input bit with_par);
    logic [63:0] f;
    f = 64'(w);
    if (with_par) f[W] = (($countones(w) % 2) != 0);
    return f;
  endfunction

  // Only the final bit of an n-bit frame is marked last
  function automatic logic [63:0] model_last(input int n);
    logic [63:0] one;
    one = 64'd1;
    return one << (n - 1);
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Wait for load_ready, offer one word for one cycle; returns in the
  // cycle right after acceptance.
  task automatic do_load(input logic [W-1:0] w);
    int t;
    t = 0;
    while (!o_lready && t < 200) begin
      @(negedge clk);
      t++;
    end
    load_wait = t;
    chk("load_ready_seen", 64'(o_lready), 64'd1);
    din_r = w;
    lv    = 1'b1;
    @(negedge clk);
    lv    = 1'b0;
    din_r = ~w;
  endtask

  // Collect nbits accepted bits. mode 0: always ready, 1: 4-cycle stalls at
  // bits 0/17/52, 2: random ready. inj >= 0 pulses a load at that bit.
  task automatic get_frame(input int nbits, input int mode, input int inj);
    int   stall;
    int   cyc;
    bit   hold;
    bit   injd;
    bit   r;
    logic ho, hl;
    stall = 0; cyc = 0; hold = 0; injd = 0; ho = 1'b0; hl = 1'b0;
    got_bits = '0; got_last = '0; busy_cnt = 0; n_unstable = 0; ngot = 0;
    while (ngot < nbits && cyc < 2000) begin
      if (o_busy) busy_cnt++;
      if (hold && (o_out !== ho || o_last !== hl)) n_unstable++;
      case (mode)
        0: r = 1'b1;
        1: begin
          if (o_valid && (ngot == 0 || ngot == 17 || ngot == 52) && stall < 4) begin
            r = 1'b0;
            stall++;
          end else begin
            r = 1'b1;
          end
        end
        default: r = 1'($urandom_range(0, 1));
      endcase
      if (inj >= 0 && !injd && ngot == inj) begin
        lv    = 1'b1;
        din_r = W'(52'hFFFF);
        injd  = 1'b1;
      end else begin
        lv = 1'b0;
      end
      rdy = r;
      if (o_valid && r && ngot < 64) begin
        got_bits[ngot] = o_out;
        got_last[ngot] = o_last;
        ngot++;
        stall = 0;
      end
      hold = o_valid && !r;
      ho   = o_out;
      hl   = o_last;
      @(negedge clk);
      cyc++;
    end
    rdy = 1'b0;
    lv  = 1'b0;
    chk("frame_complete", 64'(ngot), 64'(nbits));
  endtask

  task automatic check_frame(input string tag, input logic [W-1:0] w, input bit wp,
                             input int n, input bit want_busy);
    chk({tag, "_data"},   got_bits, model_frame(w, wp));
    chk({tag, "_last"},   got_last, model_last(n));
    chk({tag, "_stable"}, 64'(n_unstable), 64'd0);
    if (want_busy) chk({tag, "_busy_cycles"}, 64'(busy_cnt), 64'(n));
    chk({tag, "_idle_busy"},  64'(o_busy),   64'd0);
    chk({tag, "_idle_ready"}, 64'(o_lready), 64'd1);
    chk({tag, "_idle_valid"}, 64'(o_valid),  64'd0);
  endtask

  initial begin
    logic [63:0]  r64;
    logic [W-1:0] w;
    n_cmp = 0; n_err = 0;
    rst_n = 1'b0; sel = 1'b1; lv = 1'b0; rdy = 1'b0; din_r = '0; load_wait = 0;

    // Reset held for 3 cycles
    repeat (3) begin
      @(negedge clk);
      chk("rst_load_ready", 64'(bus1.load_ready), 64'd0);
    end
    chk("rst_ser_valid", 64'(bus1.ser_valid), 64'd0);
    chk("rst_ser_out",   64'(bus1.ser_out),   64'd0);
    chk("rst_ser_last",  64'(bus1.ser_last),  64'd0);
    chk("rst_busy",      64'(bus1.busy),      64'd0);
    rst_n = 1'b1;
    #1;
    chk("rel_ready_still_low", 64'(bus1.load_ready), 64'd0);
    @(negedge clk);
    chk("rel_ready_p1", 64'(bus1.load_ready), 64'd1);
    chk("rel_ready_p0", 64'(bus0.load_ready), 64'd1);

    // First load: single one in bit 0
    do_load(W'(52'h1));
    chk("lat_ready_low", 64'(o_lready), 64'd0);
    chk("lat_bit0_valid", 64'(o_valid), 64'd1);
    chk("lat_bit0_value", 64'(o_out), 64'd1);
    get_frame(W + 1, 0, -1);
    check_frame("one", W'(52'h1), 1'b1, W + 1, 1'b1);

    // All ones, then immediate reload
    do_load(W'(52'hF_FFFF_FFFF_FFFF));
    get_frame(W + 1, 0, -1);
    check_frame("ones", W'(52'hF_FFFF_FFFF_FFFF), 1'b1, W + 1, 1'b1);

    // Backpressure at bits 0, 17 and parity
    do_load(W'(52'hA_5A5A_5A5A_5A5A));
    chk("reload_gap", 64'(load_wait), 64'd0);
    get_frame(W + 1, 1, -1);
    check_frame("bp", W'(52'hA_5A5A_5A5A_5A5A), 1'b1, W + 1, 1'b0);

    // Load pulse during a frame is dropped
    r64 = {$urandom(), $urandom()};
    w   = r64[W-1:0];
    do_load(w);
    get_frame(W + 1, 0, 10);
    check_frame("busy_load", w, 1'b1, W + 1, 1'b1);

    // Random words with random ready
    for (int i = 0; i < 6; i++) begin
      r64 = {$urandom(), $urandom()};
      w   = r64[W-1:0];
      do_load(w);
      get_frame(W + 1, 2, -1);
      check_frame("rand_p1", w, 1'b1, W + 1, 1'b0);
    end

    // Reset in the middle of a frame
    w = W'(52'h1234_5678_9ABC);
    do_load(w);
    get_frame(20, 0, -1);
    chk("mid_partial", 64'(got_bits[19:0]), 64'(w[19:0]));
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 64'(o_valid),  64'd0);
    chk("mid_rst_out",   64'(o_out),    64'd0);
    chk("mid_rst_last",  64'(o_last),   64'd0);
    chk("mid_rst_busy",  64'(o_busy),   64'd0);
    chk("mid_rst_ready", 64'(o_lready), 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    do_load(W'(52'h3));
    get_frame(W + 1, 0, -1);
    check_frame("after_rst", W'(52'h3), 1'b1, W + 1, 1'b1);

    // No-parity instance
    sel = 1'b0;
    @(negedge clk);
    do_load(W'(52'h8_0000_0000_0000));
    get_frame(W, 0, -1);
    check_frame("nopar_msb", W'(52'h8_0000_0000_0000), 1'b0, W, 1'b1);
    for (int i = 0; i < 3; i++) begin
      r64 = {$urandom(), $urandom()};
      w   = r64[W-1:0];
      do_load(w);
      get_frame(W, 2, -1);
      check_frame("rand_p0", w, 1'b0, W, 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
